// File: rtl/ram_wr_post_buf_if.sv
// Handshake and RAM-side signal bundle for the write-posting buffer.
// The slave modport is the buffer's view; the master modport is the upstream/RAM-side view.
interface ram_wr_post_buf_if #(
    parameter int AW = 30,
    parameter int DW = 16
);
    logic          wr_req_valid;
    logic          wr_req_ready;
    logic [AW-1:0] wr_req_addr;
    logic [DW-1:0] wr_req_data;
    logic          rd_req_valid;
    logic [AW-1:0] rd_req_addr;
    logic          rd_rsp_valid;
    logic [DW-1:0] rd_rsp_data;
    logic          ram_wr;
    logic [AW-1:0] ram_wr_addr;
    logic [DW-1:0] ram_d_in;
    logic [AW-1:0] ram_rd_addr_a;
    logic [DW-1:0] ram_d_out_a;

    modport slave (
        input  wr_req_valid,
        output wr_req_ready,
        input  wr_req_addr,
        input  wr_req_data,
        input  rd_req_valid,
        input  rd_req_addr,
        output rd_rsp_valid,
        output rd_rsp_data,
        output ram_wr,
        output ram_wr_addr,
        output ram_d_in,
        output ram_rd_addr_a,
        input  ram_d_out_a
    );

    modport master (
        output wr_req_valid,
        input  wr_req_ready,
        output wr_req_addr,
        output wr_req_data,
        output rd_req_valid,
        output rd_req_addr,
        input  rd_rsp_valid,
        input  rd_rsp_data,
        input  ram_wr,
        input  ram_wr_addr,
        input  ram_d_in,
        input  ram_rd_addr_a,
        output ram_d_out_a
    );
endinterface

// File: rtl/ram_wr_post_buf.sv
// In-order write-posting FIFO in front of the RAM write port, with read
// forwarding from pending entries so reads always see the latest accepted write.
module ram_wr_post_buf #(
    parameter int AW    = 30,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    ram_wr_post_buf_if.slave         bus,
    input  logic                     drain_hold,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic                     idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;
    logic             r_rsp_valid;
    logic [DW-1:0]    r_rsp_data;

    logic             w_ready;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_idx;
    logic [DW-1:0]    w_fwd_data;

    always_comb begin
        w_ready = reset && (r_count < CW'(DEPTH));
        w_push  = bus.wr_req_valid && w_ready;
        w_pop   = reset && (r_count != '0) && !drain_hold;
    end

    // Walk oldest-to-youngest so the last hit (closest to the tail) wins.
    always_comb begin
        w_fwd_data = bus.ram_d_out_a;
        w_idx      = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_idx = r_head + PW'(i);
            if (r_vld[w_idx] && (r_addr[w_idx] == bus.rd_req_addr)) begin
                w_fwd_data = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_vld       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            if (w_pop) begin
                r_head        <= r_head + 1'b1;
                r_vld[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_tail        <= r_tail + 1'b1;
                r_vld[r_tail] <= 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_rsp_valid <= bus.rd_req_valid;
            if (bus.rd_req_valid) begin
                r_rsp_data <= w_fwd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.wr_req_addr;
            r_data[r_tail] <= bus.wr_req_data;
        end
    end

    assign bus.wr_req_ready  = w_ready;
    assign bus.ram_wr        = w_pop;
    assign bus.ram_wr_addr   = r_addr[r_head];
    assign bus.ram_d_in      = r_data[r_head];
    assign bus.ram_rd_addr_a = bus.rd_req_addr;
    assign bus.rd_rsp_valid  = r_rsp_valid;
    assign bus.rd_rsp_data   = r_rsp_data;
    assign buf_count         = r_count;
    assign idle              = (r_count == '0) && !r_rsp_valid;
endmodule

// File: tb/tb_ram_wr_post_buf.sv
// Directed bench for ram_wr_post_buf with a behavioural RAM, a reference
// write-queue model and a read-response scoreboard.
module tb_ram_wr_post_buf;
    localparam int AW    = 30;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          drain_hold;
    logic [CW-1:0] buf_count;
    logic          idle;

    always #5 clk = ~clk;

    ram_wr_post_buf_if #(.AW(AW), .DW(DW)) bus ();

    ram_wr_post_buf #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .drain_hold (drain_hold),
        .buf_count  (buf_count),
        .idle       (idle)
    );

    // Behavioural RAM: written by the DUT, read combinationally on port A.
    logic [DW-1:0] ram [logic [AW-1:0]];
    int            ram_ver = 0;

    function automatic logic [DW-1:0] ram_rd(input logic [AW-1:0] a);
        return ram.exists(a) ? ram[a] : '0;
    endfunction

    always @(posedge clk) begin
        if (bus.ram_wr === 1'b1) begin
            ram[bus.ram_wr_addr] = bus.ram_d_in;
            ram_ver <= ram_ver + 1;
        end
    end

    always @(bus.ram_rd_addr_a or ram_ver) bus.ram_d_out_a = ram_rd(bus.ram_rd_addr_a);

    // Reference model
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    wr_t           pend [$];
    logic [DW-1:0] sb [$];
    logic          exp_rsp_v;
    logic [DW-1:0] last_rsp;
    int            n_vec = 0;
    int            n_mis = 0;

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        for (int i = pend.size() - 1; i >= 0; i--) begin
            if (pend[i].a == a) return pend[i].d;
        end
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic          push;
        logic          pop;
        logic [DW-1:0] rexp;
        logic [DW-1:0] sexp;
        wr_t           e;
        rexp = '0;
        @(negedge clk);
        pop  = reset && (pend.size() != 0) && !drain_hold;
        push = reset && bus.wr_req_valid && (pend.size() < DEPTH);
        chk("buf_count", 64'(buf_count), 64'(pend.size()));
        chk("wr_req_ready", 64'(bus.wr_req_ready), 64'(reset && (pend.size() < DEPTH)));
        chk("ram_wr", 64'(bus.ram_wr), 64'(pop));
        if (pop) begin
            chk("ram_wr_addr", 64'(bus.ram_wr_addr), 64'(pend[0].a));
            chk("ram_d_in", 64'(bus.ram_d_in), 64'(pend[0].d));
        end
        chk("ram_rd_addr_a", 64'(bus.ram_rd_addr_a), 64'(bus.rd_req_addr));
        chk("rd_rsp_valid", 64'(bus.rd_rsp_valid), 64'(exp_rsp_v));
        if (exp_rsp_v) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(1), 64'(0));
            end else begin
                sexp = sb.pop_front();
                chk("rd_rsp_data", 64'(bus.rd_rsp_data), 64'(sexp));
                last_rsp = sexp;
            end
        end else begin
            chk("rd_rsp_hold", 64'(bus.rd_rsp_data), 64'(last_rsp));
        end
        chk("idle", 64'(idle), 64'((pend.size() == 0) && !exp_rsp_v));
        if (reset && bus.rd_req_valid) rexp = ref_rd(bus.rd_req_addr);
        @(posedge clk);
        if (!reset) begin
            pend.delete();
            sb.delete();
            exp_rsp_v = 1'b0;
            last_rsp  = '0;
        end else begin
            if (bus.rd_req_valid) sb.push_back(rexp);
            exp_rsp_v = bus.rd_req_valid;
            if (pop) begin
                e = pend.pop_front();
                ref_mem[e.a] = e.d;
            end
            if (push) pend.push_back('{bus.wr_req_addr, bus.wr_req_data});
        end
        #1;
    endtask

    task automatic set_wr(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wr_req_valid = v;
        bus.wr_req_addr  = a;
        bus.wr_req_data  = d;
    endtask

    task automatic set_rd(input logic v, input logic [AW-1:0] a);
        bus.rd_req_valid = v;
        bus.rd_req_addr  = a;
    endtask

    initial begin
        reset      = 1'b0;
        drain_hold = 1'b0;
        set_wr(1'b0, '0, '0);
        set_rd(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            ram[30'h20 + 30'(i)]     = 16'h5550 + 16'(i);
            ref_mem[30'h20 + 30'(i)] = 16'h5550 + 16'(i);
        end
        ram[30'h5]     = 16'h0000;
        ref_mem[30'h5] = 16'h0000;
        ram_ver = 1;
        repeat (2) @(posedge clk);
        #1;
        exp_rsp_v = 1'b0;
        last_rsp  = '0;
        tick();
        reset = 1'b1;

        // Reset discards buffered writes and an in-flight read
        drain_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_wr(1'b1, 30'h20 + 30'(i), 16'hDEA0 + 16'(i));
            tick();
        end
        set_wr(1'b0, '0, '0);
        set_rd(1'b1, 30'h20);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        set_rd(1'b0, '0);
        drain_hold = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            set_rd(1'b1, 30'h20 + 30'(i));
            tick();
        end
        set_rd(1'b0, '0);
        tick();

        // Fill and backpressure
        drain_hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_wr(1'b1, 30'h10 + 30'(i), 16'hA000 + 16'(i));
            tick();
        end
        set_wr(1'b1, 30'h14, 16'hA004);
        tick();
        set_wr(1'b0, '0, '0);
        drain_hold = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 5; i++) begin
            chk("fill_ram", 64'(ram_rd(30'h10 + 30'(i))), 64'(i < 4 ? 16'hA000 + 16'(i) : 16'h0000));
        end

        // Youngest matching entry wins
        drain_hold = 1'b1;
        set_wr(1'b1, 30'h3FFFFFFF, 16'h1111);
        tick();
        set_wr(1'b1, 30'h3FFFFFFF, 16'h2222);
        tick();
        set_wr(1'b0, '0, '0);
        set_rd(1'b1, 30'h3FFFFFFF);
        tick();
        set_rd(1'b0, '0);
        drain_hold = 1'b0;
        repeat (3) tick();
        set_rd(1'b1, 30'h3FFFFFFF);
        tick();
        set_rd(1'b0, '0);
        tick();

        // Forward from the head while it drains
        drain_hold = 1'b1;
        set_wr(1'b1, 30'h08000000, 16'hBEEF);
        tick();
        set_wr(1'b0, '0, '0);
        drain_hold = 1'b0;
        set_rd(1'b1, 30'h08000000);
        tick();
        tick();
        set_rd(1'b0, '0);
        tick();
        chk("bank1_ram", 64'(ram_rd(30'h08000000)), 64'(16'hBEEF));

        // Same-cycle push is invisible to a read of that address
        set_wr(1'b1, 30'h5, 16'h7777);
        set_rd(1'b1, 30'h5);
        tick();
        set_wr(1'b0, '0, '0);
        tick();
        set_rd(1'b0, '0);
        repeat (2) tick();

        // Streaming with concurrent push/drain across pointer wrap
        for (int i = 0; i < 10; i++) begin
            set_wr(1'b1, 30'h100 + 30'(i), 16'hC000 + 16'(i));
            tick();
        end
        set_wr(1'b0, '0, '0);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            set_rd(1'b1, 30'h100 + 30'(i));
            tick();
        end
        set_rd(1'b0, '0);
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            chk("stream_ram", 64'(ram_rd(30'h100 + 30'(i))), 64'(16'hC000 + 16'(i)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
